// File: rtl/mul8_seq.sv
// Sequential shift-add unsigned multiplier: one partial product per clock,
// W iterations per operation, IDLE -> RUN -> DONE handshake.
module mul8_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc_nxt;

    // One shift-add step: conditional add of the shifted multiplicand, wrapping in 2W bits.
    function automatic logic [2*W-1:0] shift_add(input logic [2*W-1:0] acc_in,
                                                 input logic [2*W-1:0] mcand_in,
                                                 input logic           bit_in);
        logic [2*W-1:0] r;
        r = acc_in;
        if (bit_in)
            r = acc_in + mcand_in;
        return r;
    endfunction

    always_comb begin
        acc_nxt = shift_add(acc, mcand, mplier[0]);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last iteration: publish the product including this edge's add.
                    if (cnt == CW'(W - 1)) begin
                        p     <= acc_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: the driver queues expected products with
// their accept cycle; a negedge monitor pops one entry per done pulse.
module tb_mul8_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           res;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    typedef struct {
        logic [2*W-1:0] prod;
        int             t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    mul8_seq #(.W(W)) dut (
        .clk   (clk),
        .res   (res),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued product and arrive W cycles after accept.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=done p=%0h required=no_done", p);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", {16'b0, p}, {16'b0, e.prod});
                    chk("latency", cyc - e.t0, W);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0 && done === 1'b0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout actual=busy%0b_done%0b required=idle", busy, done);
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input int t0);
        exp_t e;
        e.prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.t0   = t0;
        q.push_back(e);
    endtask

    // Issues one start pulse from IDLE; returns at the negedge after the accept edge.
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push(x, y, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] ca [6];
        logic [W-1:0] cb [6];

        res = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_p", {16'b0, p}, 32'd0);
        mon_en = 1'b1;

        // 0x0D * 0x0B = 0x008F, with cycle-by-cycle busy check
        op(8'h0D, 8'h0B);
        for (int k = 0; k < W; k++) begin
            chk("run_busy", {31'b0, busy}, 32'd1);
            chk("run_done", {31'b0, done}, 32'd0);
            a = 8'hAA;
            b = 8'h55;
            @(negedge clk);
        end
        @(negedge clk);
        chk("idle_after_done_busy", {31'b0, busy}, 32'd0);
        chk("idle_after_done_done", {31'b0, done}, 32'd0);
        chk("p_hold_0x8f", {16'b0, p}, 32'h008F);

        op(8'hFF, 8'hFF);
        op(8'h00, 8'h37);

        // start held high: accepts at T0, T0+10, T0+20 only
        wait_idle();
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        @(negedge clk);
        begin
            int t0;
            t0 = cyc;
            for (int k = 0; k < 3; k++) push(8'd3, 8'd5, t0 + k * (W + 2));
        end
        repeat (2 * (W + 2)) @(negedge clk);
        start = 1'b0;

        // operands scrambled during RUN must not matter
        op(8'h21, 8'h02);
        for (int k = 0; k < W; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
        end
        wait_idle();
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            chk("p_hold_0x42", {16'b0, p}, 32'h0042);
            @(negedge clk);
        end

        // reset at the 4th RUN edge aborts without a done pulse
        wait_idle();
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_p", {16'b0, p}, 32'd0);
        repeat (2 * W) @(negedge clk);
        chk("abort_p_hold", {16'b0, p}, 32'd0);

        // reset wins over start on the same edge
        a = 8'h05;
        b = 8'h05;
        start = 1'b1;
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        start = 1'b0;
        chk("res_prio_busy", {31'b0, busy}, 32'd0);
        repeat (W + 3) @(negedge clk);
        chk("res_prio_p", {16'b0, p}, 32'd0);

        ca = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'hFF, 8'h7F};
        cb = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hFE, 8'h81};
        for (int i = 0; i < 6; i++) op(ca[i], cb[i]);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op(ra, rb);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
